// File: rtl/fake_n64_controller_tx_if.sv
// Signal bundle between the controller receive stage and the response transmitter.
// The receive side (master) supplies the decoded request; the transmitter (slave) drives the line.
interface fake_n64_controller_tx_if;
    logic        tx_handoff;
    logic [7:0]  cmd;
    logic [7:0]  crc;
    logic [31:0] buttons;
    logic        pak_present;
    logic        data_tx;
    logic        cur_operation;

    modport master (
        output tx_handoff, cmd, crc, buttons, pak_present,
        input  data_tx, cur_operation
    );

    modport slave (
        input  tx_handoff, cmd, crc, buttons, pak_present,
        output data_tx, cur_operation
    );
endinterface

// File: rtl/fake_n64_controller_tx.sv
// Fake N64 controller response transmitter: on each handoff toggle it latches the decoded
// command and serialises the matching response with N64 pulse-width bit encoding.
module fake_n64_controller_tx #(
    parameter int QUARTER_TICKS       = 12,
    parameter int TURNAROUND_QUARTERS = 8
) (
    input  logic                      clk,
    input  logic                      reset,
    fake_n64_controller_tx_if.slave   bus
);
    localparam int TICK_W = (QUARTER_TICKS > 1) ? $clog2(QUARTER_TICKS) : 1;
    localparam int GAP_W  = (TURNAROUND_QUARTERS > 1) ? $clog2(TURNAROUND_QUARTERS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(QUARTER_TICKS - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(TURNAROUND_QUARTERS - 1);

    typedef enum logic [1:0] {IDLE, GAP, BIT, STOP} state_t;
    typedef enum logic [1:0] {RESP_INFO, RESP_BUTTONS, RESP_READ, RESP_WRITE} resp_t;

    logic        sync1_reg, sync2_reg, prev_reg;
    state_t      state_reg, state_next;
    resp_t       resp_reg, resp_next;
    logic [TICK_W-1:0] tick_reg, tick_next;
    logic [GAP_W-1:0]  gap_reg, gap_next;
    logic [1:0]  quarter_reg, quarter_next;
    logic [2:0]  bit_reg, bit_next;
    logic [5:0]  byte_reg, byte_next;
    logic [5:0]  last_byte_reg, last_byte_next;
    logic [7:0]  crc_reg, crc_next;
    logic [31:0] buttons_reg, buttons_next;
    logic        pak_reg, pak_next;
    logic        data_tx_reg, data_tx_next;
    logic        busy_reg, busy_next;

    logic        request;
    logic        cmd_valid;
    resp_t       cmd_resp;
    logic [5:0]  cmd_last;
    logic [7:0]  cur_byte;
    logic        cur_bit;
    logic        quarter_end;

    // The previous-value register follows the synchroniser every cycle, so toggles
    // that arrive while a response is in flight are consumed and never replayed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            prev_reg  <= 1'b0;
        end else begin
            sync1_reg <= bus.tx_handoff;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
        end
    end

    assign request     = sync2_reg != prev_reg;
    assign quarter_end = tick_reg == TICK_LAST;

    always_comb begin
        cmd_valid = 1'b1;
        cmd_resp  = RESP_INFO;
        cmd_last  = 6'd2;
        case (bus.cmd)
            8'h00, 8'hff: begin cmd_resp = RESP_INFO;    cmd_last = 6'd2;  end
            8'h01:        begin cmd_resp = RESP_BUTTONS; cmd_last = 6'd3;  end
            8'h02:        begin cmd_resp = RESP_READ;    cmd_last = 6'd32; end
            8'h03:        begin cmd_resp = RESP_WRITE;   cmd_last = 6'd0;  end
            default:      cmd_valid = 1'b0;
        endcase
    end

    always_comb begin
        cur_byte = 8'h00;
        case (resp_reg)
            RESP_INFO: begin
                case (byte_reg)
                    6'd0:    cur_byte = 8'h05;
                    6'd1:    cur_byte = 8'h00;
                    default: cur_byte = pak_reg ? 8'h01 : 8'h02;
                endcase
            end
            RESP_BUTTONS: begin
                case (byte_reg[1:0])
                    2'd0:    cur_byte = buttons_reg[31:24];
                    2'd1:    cur_byte = buttons_reg[23:16];
                    2'd2:    cur_byte = buttons_reg[15:8];
                    default: cur_byte = buttons_reg[7:0];
                endcase
            end
            RESP_READ:  cur_byte = 8'h00;
            RESP_WRITE: cur_byte = crc_reg;
            default:    cur_byte = 8'h00;
        endcase
    end

    assign cur_bit = cur_byte[3'd7 - bit_reg];

    // data_tx_next always describes the level for the quarter that starts on the next edge.
    always_comb begin
        state_next     = state_reg;
        resp_next      = resp_reg;
        tick_next      = tick_reg;
        gap_next       = gap_reg;
        quarter_next   = quarter_reg;
        bit_next       = bit_reg;
        byte_next      = byte_reg;
        last_byte_next = last_byte_reg;
        crc_next       = crc_reg;
        buttons_next   = buttons_reg;
        pak_next       = pak_reg;
        data_tx_next   = data_tx_reg;
        busy_next      = busy_reg;

        case (state_reg)
            IDLE: begin
                data_tx_next = 1'b1;
                busy_next    = 1'b0;
                if (request && cmd_valid) begin
                    state_next     = GAP;
                    busy_next      = 1'b1;
                    resp_next      = cmd_resp;
                    last_byte_next = cmd_last;
                    crc_next       = bus.crc;
                    buttons_next   = bus.buttons;
                    pak_next       = bus.pak_present;
                    tick_next      = '0;
                    gap_next       = '0;
                    quarter_next   = 2'd0;
                    bit_next       = 3'd0;
                    byte_next      = 6'd0;
                end
            end
            GAP: begin
                tick_next = tick_reg + 1'b1;
                if (quarter_end) begin
                    tick_next = '0;
                    if (gap_reg == GAP_LAST) begin
                        state_next   = BIT;
                        quarter_next = 2'd0;
                        data_tx_next = 1'b0;
                    end else begin
                        gap_next = gap_reg + 1'b1;
                    end
                end
            end
            BIT: begin
                tick_next = tick_reg + 1'b1;
                if (quarter_end) begin
                    tick_next = '0;
                    if (quarter_reg == 2'd3) begin
                        quarter_next = 2'd0;
                        data_tx_next = 1'b0;
                        bit_next     = bit_reg + 1'b1;
                        if (bit_reg == 3'd7) begin
                            if (byte_reg == last_byte_reg) state_next = STOP;
                            else                           byte_next  = byte_reg + 1'b1;
                        end
                    end else begin
                        quarter_next = quarter_reg + 1'b1;
                        data_tx_next = (quarter_reg == 2'd2) ? 1'b1 : cur_bit;
                    end
                end
            end
            STOP: begin
                tick_next = tick_reg + 1'b1;
                if (quarter_end) begin
                    tick_next = '0;
                    if (quarter_reg == 2'd3) begin
                        state_next   = IDLE;
                        busy_next    = 1'b0;
                        data_tx_next = 1'b1;
                        quarter_next = 2'd0;
                        bit_next     = 3'd0;
                        byte_next    = 6'd0;
                        gap_next     = '0;
                    end else begin
                        quarter_next = quarter_reg + 1'b1;
                        data_tx_next = quarter_reg >= 2'd1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            resp_reg      <= RESP_INFO;
            tick_reg      <= '0;
            gap_reg       <= '0;
            quarter_reg   <= 2'd0;
            bit_reg       <= 3'd0;
            byte_reg      <= 6'd0;
            last_byte_reg <= 6'd0;
            crc_reg       <= 8'h00;
            buttons_reg   <= 32'h0;
            pak_reg       <= 1'b0;
            data_tx_reg   <= 1'b1;
            busy_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            resp_reg      <= resp_next;
            tick_reg      <= tick_next;
            gap_reg       <= gap_next;
            quarter_reg   <= quarter_next;
            bit_reg       <= bit_next;
            byte_reg      <= byte_next;
            last_byte_reg <= last_byte_next;
            crc_reg       <= crc_next;
            buttons_reg   <= buttons_next;
            pak_reg       <= pak_next;
            data_tx_reg   <= data_tx_next;
            busy_reg      <= busy_next;
        end
    end

    assign bus.data_tx       = data_tx_reg;
    assign bus.cur_operation = busy_reg;
endmodule
